// File: rtl/byte_output_buffer_pkg.sv
// Shared definitions for the byte output buffer: flag encodings, FSM state type
// and the flag-to-byte-count mapping.
package byte_output_buffer_pkg;

   localparam logic [1:0] FLAG_NONE  = 2'b00;
   localparam logic [1:0] FLAG_ONE   = 2'b01;
   localparam logic [1:0] FLAG_TWO   = 2'b11;
   localparam logic [1:0] FLAG_THREE = 2'b10;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_t;

   // The flag encoding is not binary-ordered: 10 means three bytes.
   function automatic logic [1:0] byte_count(input logic [1:0] flag);
      case (flag)
         FLAG_ONE:   return 2'd1;
         FLAG_TWO:   return 2'd2;
         FLAG_THREE: return 2'd3;
         default:    return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/byte_output_buffer_ring.sv
// Ring storage for the byte output buffer: data and last-tag arrays with three
// write ports at consecutive addresses and one combinational read port.
module byte_ring_buffer
   import byte_output_buffer_pkg::*;
#(
   parameter int OUTPUT_DATA_WIDTH = 8,
   parameter int BUFFER_DEPTH      = 8,
   localparam int AW               = $clog2(BUFFER_DEPTH)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [AW-1:0]                wr_addr,
   input  logic [2:0]                   wr_en,
   input  logic [2:0]                   wr_tag,
   input  logic [OUTPUT_DATA_WIDTH-1:0] wr_data_1,
   input  logic [OUTPUT_DATA_WIDTH-1:0] wr_data_2,
   input  logic [OUTPUT_DATA_WIDTH-1:0] wr_data_3,
   input  logic [AW-1:0]                rd_addr,
   output logic [OUTPUT_DATA_WIDTH-1:0] rd_data,
   output logic                         rd_tag
);

   logic [OUTPUT_DATA_WIDTH-1:0] data_mem [BUFFER_DEPTH];
   logic [BUFFER_DEPTH-1:0]      tag_mem;
   logic [AW-1:0]                addr_2;
   logic [AW-1:0]                addr_3;

   // Depth is at least four, so the three write addresses never collide.
   assign addr_2 = wr_addr + AW'(1);
   assign addr_3 = wr_addr + AW'(2);

   always_ff @(posedge clk) begin
      if (wr_en[0]) data_mem[wr_addr] <= wr_data_1;
      if (wr_en[1]) data_mem[addr_2]  <= wr_data_2;
      if (wr_en[2]) data_mem[addr_3]  <= wr_data_3;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         tag_mem <= '0;
      end else begin
         if (wr_en[0]) tag_mem[wr_addr] <= wr_tag[0];
         if (wr_en[1]) tag_mem[addr_2]  <= wr_tag[1];
         if (wr_en[2]) tag_mem[addr_3]  <= wr_tag[2];
      end
   end

   assign rd_data = data_mem[rd_addr];
   assign rd_tag  = tag_mem[rd_addr];

endmodule

// File: rtl/byte_output_buffer.sv
// Byte output buffer: accepts 0-3 resolved bytes per cycle from carry
// propagation and emits them one per cycle, holding off input while a frame drains.
module byte_output_buffer
   import byte_output_buffer_pkg::*;
#(
   parameter int OUTPUT_DATA_WIDTH = 8,
   parameter int BUFFER_DEPTH      = 8,
   localparam int AW               = $clog2(BUFFER_DEPTH)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic [1:0]                   in_flag,
   input  logic                         in_flag_last,
   input  logic [OUTPUT_DATA_WIDTH-1:0] in_bitstream_1,
   input  logic [OUTPUT_DATA_WIDTH-1:0] in_bitstream_2,
   input  logic [OUTPUT_DATA_WIDTH-1:0] in_bitstream_3,
   output logic                         in_ready,
   output logic                         out_valid,
   output logic [OUTPUT_DATA_WIDTH-1:0] out_byte,
   output logic                         out_last,
   input  logic                         out_ready,
   output logic [AW:0]                  occupancy,
   output logic                         err_empty_last
);

   localparam logic [AW:0] DEPTH_L = (AW+1)'(BUFFER_DEPTH);

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          empty_drain;
   logic [1:0]    n_bytes;
   logic          push;
   logic          pop;
   logic [2:0]    wr_en;
   logic [2:0]    wr_tag;
   logic          head_tag;
   logic [AW:0]   push_cnt;
   logic [AW:0]   pop_cnt;
   logic [AW:0]   free_slots;

   assign n_bytes    = byte_count(in_flag);
   assign push       = in_valid && in_ready;
   assign pop        = out_valid && out_ready;
   assign push_cnt   = push ? (AW+1)'(n_bytes) : '0;
   assign pop_cnt    = {{AW{1'b0}}, pop};
   assign free_slots = DEPTH_L - occupancy;

   // Only the last byte written by a frame-closing push carries the tag.
   always_comb begin
      wr_en  = '0;
      wr_tag = '0;
      for (int i = 0; i < 3; i++) begin
         wr_en[i]  = push && (n_bytes > 2'(i));
         wr_tag[i] = in_flag_last && (n_bytes == 2'(i + 1));
      end
   end

   byte_ring_buffer #(
      .OUTPUT_DATA_WIDTH (OUTPUT_DATA_WIDTH),
      .BUFFER_DEPTH      (BUFFER_DEPTH)
   ) u_ring (
      .clk       (clk),
      .reset     (reset),
      .wr_addr   (wr_ptr),
      .wr_en     (wr_en),
      .wr_tag    (wr_tag),
      .wr_data_1 (in_bitstream_1),
      .wr_data_2 (in_bitstream_2),
      .wr_data_3 (in_bitstream_3),
      .rd_addr   (rd_ptr),
      .rd_data   (out_byte),
      .rd_tag    (head_tag)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         occupancy      <= '0;
         empty_drain    <= 1'b0;
         err_empty_last <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(n_bytes);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         occupancy <= occupancy + push_cnt - pop_cnt;
         if (push && in_flag_last) begin
            empty_drain <= (n_bytes == 2'd0);
            if (n_bytes == 2'd0) err_empty_last <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= RUN;
      else        state <= state_nxt;
   end

   // A frame closed with no bytes has no tag to wait for, so drain to empty instead.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:   if (push && in_flag_last) state_nxt = DRAIN;
         DRAIN: if ((pop && out_last) || (empty_drain && occupancy == '0)) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      in_ready  = (state == RUN) && (free_slots >= (AW+1)'(3));
      out_valid = (occupancy != '0);
      out_last  = head_tag && out_valid;
   end

endmodule
